// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM states, oversampling constants
// and the baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    // Clocks per oversample tick.
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / (OVERSAMPLE * baud);
    endfunction

endpackage

// File: rtl/rx_tick_gen.sv
// Free-running 16x oversample tick generator; restart_i realigns the phase to
// a detected start edge.
module rx_tick_gen #(
    parameter int DIV = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive path: 16x oversampled start/data/stop recovery with a
// valid/ready byte interface, framing-error pulse and sticky overrun flag.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CLK_FREQ  = 16_000_000,
    parameter int BAUD_RATE = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             frame_error,
    output logic             overrun,
    output logic             busy
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int NW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [3:0]    S_MID  = 4'(MID_SAMPLE);
    localparam logic [3:0]    S_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(WIDTH - 1);

    if ((CLK_FREQ % (OVERSAMPLE * BAUD_RATE)) != 0 || DIV < 1) begin : g_bad_baud
        $error("uart_receiver: CLK_FREQ must be a multiple of 16*BAUD_RATE");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("uart_receiver: WIDTH must be at least 2");
    end

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    uart_state_e      state_q, state_d;
    logic [3:0]       s_q, s_d;
    logic [NW-1:0]    n_q, n_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             fe_q, fe_d;
    logic             ovr_q, ovr_d;
    logic             busy_q, busy_d;

    logic tick_s;
    logic fall_s;
    logic restart_s;
    logic stop_sample_s;
    logic commit_s;
    logic hs_s;

    rx_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk_i     (clk),
        .reset_i   (reset),
        .restart_i (restart_s),
        .tick_o    (tick_s)
    );

    assign fall_s = rx_prev_q & ~rx_sync_q;

    // Frame sequencing: start verification, data shifting, stop check.
    always_comb begin
        state_d       = state_q;
        s_d           = s_q;
        n_d           = n_q;
        shift_d       = shift_q;
        restart_s     = 1'b0;
        stop_sample_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall_s) begin
                    state_d   = START;
                    s_d       = 4'd0;
                    restart_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    if (s_q == S_MID) begin
                        s_d     = 4'd0;
                        n_d     = '0;
                        state_d = rx_sync_q ? IDLE : DATA;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            DATA: begin
                if (tick_s) begin
                    if (s_q == S_LAST) begin
                        s_d     = 4'd0;
                        shift_d = {rx_sync_q, shift_q[WIDTH-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            STOP: begin
                // Leaving mid-stop-bit lets a back-to-back start edge be caught.
                if (tick_s) begin
                    if (s_q == S_LAST) begin
                        s_d           = 4'd0;
                        stop_sample_s = 1'b1;
                        state_d       = rx_sync_q ? IDLE : WAIT_IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            WAIT_IDLE: begin
                if (rx_sync_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                s_d     = 4'd0;
                n_d     = '0;
            end
        endcase
    end

    assign hs_s     = valid_q & ready;
    assign commit_s = stop_sample_s & rx_sync_q;

    // Output register next-state: byte commit, handshake and status flags.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        fe_d    = stop_sample_s & ~rx_sync_q;
        busy_d  = (state_d != IDLE);
        if (commit_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !hs_s) begin
                ovr_d = 1'b1;
            end else begin
                ovr_d = 1'b0;
            end
        end else if (hs_s) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // All state, with the rx synchronizer resetting to the idle level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            s_q       <= 4'd0;
            n_q       <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ovr_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ovr_q     <= ovr_d;
            busy_q    <= busy_d;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_error = fe_q;
    assign overrun     = ovr_q;
    assign busy        = busy_q;

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive path; the counterpart of the transmit path in the same UART core. Samples the asynchronous `rx` line at 16x the baud rate, recovers 8N1 frames (1 start, WIDTH data bits LSB-first, 1 stop) and presents each byte on a valid/ready handshake. Sits between the board-level RX pin and the consumer logic, sharing the clock domain and baud configuration with the transmitter.

## Interface
- `WIDTH`, 8: data bits per frame.
- `CLK_FREQ`, 16_000_000: clock frequency in Hz.
- `BAUD_RATE`, 1_000_000: line rate in baud. `CLK_FREQ` must be a multiple of 16*`BAUD_RATE` (elaboration error otherwise).
- `clk`  in  1  sole clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-low reset.
- `rx`  in  1  asynchronous serial line, idle high.
- `data`  out  WIDTH  received byte; stable while `valid` is high.
- `valid`  out  1  byte available; held until accepted.
- `ready`  in  1  consumer accepts `data` when `valid && ready`.
- `frame_error`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  sticky: a frame completed while `valid` was high; cleared by reset or by a handshake.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer (reset value 1) before any use.
- Tick generator: counter 0..DIV-1, DIV = CLK_FREQ/(16*BAUD_RATE); one-cycle `tick` at wrap. Counter runs freely, but is restarted to 0 on start-edge detection so sampling phase is aligned to the edge.
- FSM, sample counter `s` (0..15) and bit counter `n` (0..WIDTH-1), advanced only on `tick`:
  - IDLE: on synchronized falling edge -> START, s=0.
  - START: at s=7 (mid-bit) sample; low -> DATA, s=0, n=0; high -> IDLE (glitch rejected, no flags).
  - DATA: at s=15 sample into shift register MSB and shift right (LSB-first); n==WIDTH-1 -> STOP, else n++.
  - STOP: at s=15 sample; high -> commit shift register to `data`, set `valid`, -> IDLE. Low -> pulse `frame_error`, `data`/`valid` unchanged, -> WAIT_IDLE.
  - WAIT_IDLE: wait for synchronized `rx` high (break condition), then -> IDLE.
- Commit with `valid` already high and no handshake that cycle: `data` overwritten with the new byte, `valid` stays high, `overrun` set.
- Commit and handshake in the same cycle: handshake consumes the old byte; new byte loaded, `valid` stays high, `overrun` not set.
- Handshake: `valid && ready` clears `valid` next cycle and clears `overrun`.
- Reset mid-frame: FSM to IDLE immediately; partial frame discarded; next falling edge starts a fresh frame.

## Timing
- Reset values: `data`=0, `valid`=0, `frame_error`=0, `overrun`=0, `busy`=0, FSM IDLE, counters 0.
- Synchronizer latency: 2 clk.
- Start bit verified at 8 ticks after the edge; data bit k sampled at (8+16(k+1)) ticks; stop bit at (8+16(WIDTH+1)) ticks.
- `valid` rises 1 clk after the stop-bit sample (registered); total ~ 9.5 bit periods + 3 clk from line edge.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge at the nominal stop end is caught; no idle gap required.
- `busy` registered, tracks FSM state.

## Structure
- Package `uart_pkg`: FSM state enum (IDLE, START, DATA, STOP, WAIT_IDLE), `OVERSAMPLE`=16, `MID_SAMPLE`=7, divider function `baud_div(clk_freq, baud)`; shared with the transmit side.
- Sub-module `rx_tick_gen`: 16x tick counter with synchronous restart input; everything else in `uart_receiver`.

## Test plan
Defaults (DIV=1, 16 clk/bit):
- Send 0xA5, `ready`=1 -> `valid` for one cycle with `data`=0xA5, no flags.
- Send 0x3C, `ready`=0 for 200 clk -> `valid` held, `data`=0x3C stable until `ready`, then `valid` drops next cycle.
- Send 0x11 then 0x22 with `ready`=0 -> `data`=0x22, `overrun`=1; assert `ready` -> `valid`, `overrun` cleared.
- Send 0x55 with stop bit low, then hold `rx` low 40 clk -> one `frame_error` pulse, `valid` stays 0, `busy` high until `rx` returns high.
- 4-clk low glitch on idle line -> no `valid`, no `frame_error`, `busy` returns 0 after 8 ticks.
- Assert `reset` after 4 data bits, release, send 0xF0 -> only 0xF0 delivered, no flags.
